mem_arbiter: RTL and testbench

Arbiter/sequencer sharing one single-port, variable-latency main memory between the pipeline's instruction-fetch port (IF stage) and data port (MEM stage). Grants one request at a time, drives the memory handshake, returns read data with a one-cycle ack pulse, and drives a pipeline stall while any request is outstanding. A watchdog bounds every memory transaction.

---
 rtl/cpu_mem_pkg.sv | 25 ++
 rtl/mem_timeout_cnt.sv | 49 ++++
 rtl/mem_arbiter.sv | 156 +++++++++++++++
 tb/tb_mem_arbiter.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_mem_pkg.sv
// ---------------------------------------------------------------------------
// cpu_mem_pkg
// Shared definitions for the instruction/data memory arbiter:
//   - default address/data widths and watchdog length
//   - arbiter state enumeration
//   - is_busy(): true while a memory transaction is in flight
// ---------------------------------------------------------------------------
package cpu_mem_pkg;

  localparam int unsigned DEF_ADDR_W  = 32;
  localparam int unsigned DEF_DATA_W  = 32;
  localparam int unsigned DEF_TIMEOUT = 64;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_DM_BUSY = 2'd1,
    ST_IF_BUSY = 2'd2,
    ST_RESP    = 2'd3
  } arb_state_t;

  function automatic logic is_busy(input arb_state_t s);
    return (s == ST_DM_BUSY) || (s == ST_IF_BUSY);
  endfunction

endpackage

// File: rtl/mem_timeout_cnt.sv
// ---------------------------------------------------------------------------
// mem_timeout_cnt
// Watchdog counter for one memory transaction. Cleared on a grant, counts
// while enabled and saturates at TIMEOUT-1, where tc_o is raised.
// Ports:
//   clk_i  clock, rising edge
//   rst_i  synchronous active-low reset
//   clr_i  clear to zero (has priority over en_i)
//   en_i   count enable (one increment per cycle)
//   tc_o   terminal count: counter == TIMEOUT-1
// ---------------------------------------------------------------------------
module mem_timeout_cnt
  import cpu_mem_pkg::*;
#(
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;

  always_comb begin
    cnt_next = cnt_reg;
    if (clr_i) begin
      cnt_next = '0;
    end else if (en_i && (cnt_reg != TC_VAL)) begin
      cnt_next = cnt_reg + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

  assign tc_o = (cnt_reg == TC_VAL);

endmodule

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
// Shares one single-port, variable-latency memory between the instruction
// fetch port (if_*) and the data port (dm_*). One transaction at a time;
// the data port wins ties because it belongs to the older instruction.
// Each transaction ends with a single RESP cycle carrying the ack pulse,
// followed by one IDLE cycle in which the next grant is decided.
// A watchdog forces completion (data 0, sticky err_o) if memory never acks.
// Ports:
//   clk_i, rst_i            clock, synchronous active-low reset
//   start_i                 allow new grants
//   if_req_i/if_addr_i      fetch request; if_data_o/if_ack_o response
//   dm_req_i/dm_we_i/...    data request; dm_rdata_o/dm_ack_o response
//   mem_*_o / mem_*_i       memory handshake (req held until mem_ack_i)
//   stall_o                 combinational pipeline stall
//   err_o                   sticky watchdog timeout flag
// ---------------------------------------------------------------------------
module mem_arbiter
  import cpu_mem_pkg::*;
#(
  parameter int unsigned ADDR_W  = DEF_ADDR_W,
  parameter int unsigned DATA_W  = DEF_DATA_W,
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic [DATA_W-1:0] if_data_o,
  output logic              if_ack_o,
  input  logic              dm_req_i,
  input  logic              dm_we_i,
  input  logic [ADDR_W-1:0] dm_addr_i,
  input  logic [DATA_W-1:0] dm_wdata_i,
  output logic [DATA_W-1:0] dm_rdata_o,
  output logic              dm_ack_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  input  logic              mem_ack_i,
  output logic              stall_o,
  output logic              err_o
);

  arb_state_t        state_reg;
  arb_state_t        state_next;
  logic              owner_dm_reg;   // granted port of the current/last txn
  logic              mem_we_reg;
  logic [ADDR_W-1:0] mem_addr_reg;
  logic [DATA_W-1:0] mem_wdata_reg;
  logic [DATA_W-1:0] if_data_reg;
  logic [DATA_W-1:0] dm_rdata_reg;
  logic              err_reg;

  logic grant_dm;
  logic grant_if;
  logic finish_ok;
  logic finish_to;
  logic busy;
  logic tc;

  assign busy = is_busy(state_reg);

  mem_timeout_cnt #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (grant_dm | grant_if),
    .en_i  (busy),
    .tc_o  (tc)
  );

  always_comb begin
    state_next = state_reg;
    grant_dm   = 1'b0;
    grant_if   = 1'b0;
    finish_ok  = 1'b0;
    finish_to  = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (start_i && dm_req_i) begin
          grant_dm   = 1'b1;
          state_next = ST_DM_BUSY;
        end else if (start_i && if_req_i) begin
          grant_if   = 1'b1;
          state_next = ST_IF_BUSY;
        end
      end
      ST_DM_BUSY, ST_IF_BUSY: begin
        // A real ack arriving on the terminal-count cycle still wins.
        if (mem_ack_i) begin
          finish_ok  = 1'b1;
          state_next = ST_RESP;
        end else if (tc) begin
          finish_to  = 1'b1;
          state_next = ST_RESP;
        end
      end
      ST_RESP: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_reg     <= ST_IDLE;
      owner_dm_reg  <= 1'b0;
      mem_we_reg    <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
      if_data_reg   <= '0;
      dm_rdata_reg  <= '0;
      err_reg       <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (grant_dm) begin
        owner_dm_reg  <= 1'b1;
        mem_we_reg    <= dm_we_i;
        mem_addr_reg  <= dm_addr_i;
        mem_wdata_reg <= dm_wdata_i;
      end else if (grant_if) begin
        owner_dm_reg  <= 1'b0;
        mem_we_reg    <= 1'b0;
        mem_addr_reg  <= if_addr_i;
        mem_wdata_reg <= '0;
      end
      if (finish_ok || finish_to) begin
        if (owner_dm_reg) begin
          // Writes return no data; a timed-out access returns zero.
          dm_rdata_reg <= (finish_to || mem_we_reg) ? '0 : mem_rdata_i;
        end else begin
          if_data_reg <= finish_to ? '0 : mem_rdata_i;
        end
      end
      if (finish_to) begin
        err_reg <= 1'b1;
      end
    end
  end

  assign mem_req_o   = busy;
  assign mem_we_o    = busy & mem_we_reg;
  assign mem_addr_o  = mem_addr_reg;
  assign mem_wdata_o = mem_wdata_reg;
  assign if_data_o   = if_data_reg;
  assign dm_rdata_o  = dm_rdata_reg;
  assign if_ack_o    = (state_reg == ST_RESP) && !owner_dm_reg;
  assign dm_ack_o    = (state_reg == ST_RESP) && owner_dm_reg;
  assign err_o       = err_reg;
  assign stall_o     = (if_req_i && !if_ack_o) || (dm_req_i && !dm_ack_o);

endmodule

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter
// Directed scenarios followed by randomized traffic. A transaction-level
// reference model (current memory transaction, its elapsed busy cycles,
// pending response, held data registers) predicts every output each cycle.
// ---------------------------------------------------------------------------
module tb_mem_arbiter;

  localparam int TMO = 8;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic [31:0] if_data_o;
  logic        if_ack_o;
  logic        dm_req_i;
  logic        dm_we_i;
  logic [31:0] dm_addr_i;
  logic [31:0] dm_wdata_i;
  logic [31:0] dm_rdata_o;
  logic        dm_ack_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_rdata_i;
  logic        mem_ack_i;
  logic        stall_o;
  logic        err_o;

  mem_arbiter #(
    .ADDR_W  (32),
    .DATA_W  (32),
    .TIMEOUT (TMO)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .start_i     (start_i),
    .if_req_i    (if_req_i),
    .if_addr_i   (if_addr_i),
    .if_data_o   (if_data_o),
    .if_ack_o    (if_ack_o),
    .dm_req_i    (dm_req_i),
    .dm_we_i     (dm_we_i),
    .dm_addr_i   (dm_addr_i),
    .dm_wdata_i  (dm_wdata_i),
    .dm_rdata_o  (dm_rdata_o),
    .dm_ack_o    (dm_ack_o),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_rdata_i (mem_rdata_i),
    .mem_ack_i   (mem_ack_i),
    .stall_o     (stall_o),
    .err_o       (err_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_err    = 0;
  int n_txn    = 0;

  // Reference model state (describes the cycle currently being observed)
  bit          m_busy    = 1'b0;  // a memory transaction is in flight
  bit          m_dm      = 1'b0;  // it belongs to the data port
  bit          m_we      = 1'b0;
  logic [31:0] m_addr    = '0;
  logic [31:0] m_wdata   = '0;
  int          m_elapsed = 0;     // busy cycles already completed
  int          m_lat     = 0;     // random phase: busy cycle index of mem ack
  bit          m_resp    = 1'b0;  // this cycle is the response cycle
  bit          m_resp_dm = 1'b0;
  logic [31:0] m_if_data = '0;
  logic [31:0] m_dm_data = '0;
  bit          m_err     = 1'b0;

  function automatic void chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  task automatic finish_txn(input bit timed_out, input logic [31:0] data);
    m_busy    = 1'b0;
    m_resp    = 1'b1;
    m_resp_dm = m_dm;
    if (m_dm) m_dm_data = data;
    else      m_if_data = data;
    if (timed_out) m_err = 1'b1;
    n_txn++;
    $display("txn %0d port=%s we=%0d addr=%h data=%h busy_cycles=%0d timeout=%0d",
             n_txn, m_dm ? "dm" : "if", m_we, m_addr, data, m_elapsed, timed_out);
  endtask

  // Advance the model across one clock edge using the inputs now applied.
  task automatic model_update();
    if (!rst_i) begin
      m_busy    = 1'b0;
      m_resp    = 1'b0;
      m_err     = 1'b0;
      m_if_data = '0;
      m_dm_data = '0;
      m_elapsed = 0;
    end else if (m_resp) begin
      m_resp = 1'b0;
    end else if (m_busy) begin
      m_elapsed++;
      if (mem_ack_i)
        finish_txn(1'b0, (m_dm && m_we) ? 32'h0 : mem_rdata_i);
      else if (m_elapsed == TMO)
        finish_txn(1'b1, 32'h0);
    end else if (start_i && (dm_req_i || if_req_i)) begin
      m_busy    = 1'b1;
      m_dm      = dm_req_i;
      m_we      = dm_req_i ? dm_we_i : 1'b0;
      m_addr    = dm_req_i ? dm_addr_i : if_addr_i;
      m_wdata   = dm_wdata_i;
      m_elapsed = 0;
      m_lat     = int'($urandom_range(0, 9));
    end
  endtask

  task automatic compare_outputs();
    chk1("mem_req", mem_req_o, m_busy);
    chk1("mem_we", mem_we_o, m_busy && m_we);
    if (m_busy) chk32("mem_addr", mem_addr_o, m_addr);
    if (m_busy && m_we) chk32("mem_wdata", mem_wdata_o, m_wdata);
    chk1("if_ack", if_ack_o, m_resp && !m_resp_dm);
    chk1("dm_ack", dm_ack_o, m_resp && m_resp_dm);
    chk32("if_data", if_data_o, m_if_data);
    chk32("dm_rdata", dm_rdata_o, m_dm_data);
    chk1("err", err_o, m_err);
  endtask

  // Called just after a negedge with inputs applied for this cycle.
  // Returns at the next negedge after checking the new cycle's outputs.
  task automatic step();
    logic exp_stall;
    #1;
    exp_stall = (if_req_i && !(m_resp && !m_resp_dm)) ||
                (dm_req_i && !(m_resp && m_resp_dm));
    chk1("stall", stall_o, exp_stall);
    model_update();
    @(posedge clk_i);
    @(negedge clk_i);
    compare_outputs();
  endtask

  initial begin
    rst_i = 1'b0; start_i = 1'b0;
    if_req_i = 1'b0; if_addr_i = '0;
    dm_req_i = 1'b0; dm_we_i = 1'b0; dm_addr_i = '0; dm_wdata_i = '0;
    mem_rdata_i = '0; mem_ack_i = 1'b0;
    @(negedge clk_i);

    // Reset state
    step(); step();
    chk1("rst_mem_req", mem_req_o, 1'b0);
    chk1("rst_err", err_o, 1'b0);
    chk32("rst_if_data", if_data_o, 32'h0);
    chk32("rst_dm_rdata", dm_rdata_o, 32'h0);

    // Lone fetch, memory acks 4 cycles after mem_req rises
    rst_i = 1'b1; start_i = 1'b1; if_req_i = 1'b1; if_addr_i = 32'h40;
    step();
    chk1("fetch_req", mem_req_o, 1'b1);
    chk32("fetch_addr", mem_addr_o, 32'h40);
    chk1("fetch_stall", stall_o, 1'b1);
    repeat (4) step();
    chk1("fetch_req_held", mem_req_o, 1'b1);
    mem_ack_i = 1'b1; mem_rdata_i = 32'h8C020004;
    step();
    chk1("fetch_ack", if_ack_o, 1'b1);
    chk32("fetch_data", if_data_o, 32'h8C020004);
    chk1("fetch_stall_ack", stall_o, 1'b0);
    mem_ack_i = 1'b0; if_req_i = 1'b0;
    step();
    chk1("fetch_ack_pulse", if_ack_o, 1'b0);
    chk32("fetch_data_hold", if_data_o, 32'h8C020004);

    // Tie: data port first, then fetch
    if_req_i = 1'b1; if_addr_i = 32'h200;
    dm_req_i = 1'b1; dm_we_i = 1'b0; dm_addr_i = 32'h100;
    step();
    chk32("tie_first_addr", mem_addr_o, 32'h100);
    mem_ack_i = 1'b1; mem_rdata_i = 32'h11112222;
    step();
    chk1("tie_dm_ack", dm_ack_o, 1'b1);
    chk1("tie_if_noack", if_ack_o, 1'b0);
    chk32("tie_dm_data", dm_rdata_o, 32'h11112222);
    dm_req_i = 1'b0; mem_ack_i = 1'b0;
    step();
    chk1("tie_gap", mem_req_o, 1'b0);
    step();
    chk32("tie_second_addr", mem_addr_o, 32'h200);
    mem_ack_i = 1'b1; mem_rdata_i = 32'h33334444;
    step();
    chk1("tie_if_ack", if_ack_o, 1'b1);
    chk32("tie_if_data", if_data_o, 32'h33334444);
    if_req_i = 1'b0; mem_ack_i = 1'b0;
    step();

    // Data write
    dm_req_i = 1'b1; dm_we_i = 1'b1; dm_addr_i = 32'h8; dm_wdata_i = 32'hDEADBEEF;
    step();
    chk1("wr_we", mem_we_o, 1'b1);
    chk32("wr_wdata", mem_wdata_o, 32'hDEADBEEF);
    chk32("wr_addr", mem_addr_o, 32'h8);
    mem_ack_i = 1'b1; mem_rdata_i = 32'h5555AAAA;
    step();
    chk1("wr_ack", dm_ack_o, 1'b1);
    chk32("wr_rdata_zero", dm_rdata_o, 32'h0);
    dm_req_i = 1'b0; dm_we_i = 1'b0; mem_ack_i = 1'b0;
    step();

    // Timeout: no memory ack at all
    if_req_i = 1'b1; if_addr_i = 32'h300;
    step();
    repeat (TMO - 1) step();
    chk1("to_last_busy", mem_req_o, 1'b1);
    step();
    chk1("to_ack", if_ack_o, 1'b1);
    chk32("to_data", if_data_o, 32'h0);
    chk1("to_err", err_o, 1'b1);
    if_req_i = 1'b0;
    step();
    dm_req_i = 1'b1; dm_addr_i = 32'h10;
    step();
    mem_ack_i = 1'b1; mem_rdata_i = 32'hA5A5A5A5;
    step();
    chk1("to_good_ack", dm_ack_o, 1'b1);
    chk32("to_good_data", dm_rdata_o, 32'hA5A5A5A5);
    chk1("to_err_sticky", err_o, 1'b1);
    dm_req_i = 1'b0; mem_ack_i = 1'b0;
    step();

    // Reset while the data port is being served
    dm_req_i = 1'b1; dm_addr_i = 32'h20;
    step(); step();
    rst_i = 1'b0; dm_req_i = 1'b0;
    step();
    chk1("mrst_req", mem_req_o, 1'b0);
    chk1("mrst_err", err_o, 1'b0);
    chk1("mrst_noack", dm_ack_o, 1'b0);
    rst_i = 1'b1; mem_ack_i = 1'b1; mem_rdata_i = 32'hFFFFFFFF;
    step();
    chk1("late_ack_noack", dm_ack_o, 1'b0);
    chk32("late_ack_data", dm_rdata_o, 32'h0);
    mem_ack_i = 1'b0;
    step();
    chk1("late_ack_idle", mem_req_o, 1'b0);

    // start_i low holds off grants
    start_i = 1'b0;
    if_req_i = 1'b1; if_addr_i = 32'h44;
    dm_req_i = 1'b1; dm_addr_i = 32'h48;
    step(); step();
    chk1("nostart_req", mem_req_o, 1'b0);
    chk1("nostart_stall", stall_o, 1'b1);
    start_i = 1'b1;
    step();
    chk1("start_req", mem_req_o, 1'b1);
    chk32("start_addr", mem_addr_o, 32'h48);
    mem_ack_i = 1'b1; mem_rdata_i = 32'h1;
    step();
    dm_req_i = 1'b0; mem_ack_i = 1'b0;
    step(); step();
    chk32("start_if_addr", mem_addr_o, 32'h44);
    mem_ack_i = 1'b1; mem_rdata_i = 32'h2;
    step();
    chk1("start_if_ack", if_ack_o, 1'b1);
    if_req_i = 1'b0; mem_ack_i = 1'b0;
    step();

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      rst_i   = ($urandom_range(0, 299) != 0);
      start_i = ($urandom_range(0, 9) != 0);
      if (!if_req_i || (m_resp && !m_resp_dm)) begin
        if_req_i  = ($urandom_range(0, 2) == 0);
        if_addr_i = $urandom & 32'hFFFF_FFFC;
      end else if ($urandom_range(0, 49) == 0) begin
        if_req_i = 1'b0;
      end
      if (!dm_req_i || (m_resp && m_resp_dm)) begin
        dm_req_i   = ($urandom_range(0, 2) == 0);
        dm_we_i    = ($urandom_range(0, 1) == 1);
        dm_addr_i  = $urandom & 32'hFFFF_FFFC;
        dm_wdata_i = $urandom;
      end else if ($urandom_range(0, 49) == 0) begin
        dm_req_i = 1'b0;
      end
      mem_ack_i   = m_busy ? (m_elapsed == m_lat) : ($urandom_range(0, 9) == 0);
      mem_rdata_i = $urandom;
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
